// File: rtl/product_acc_pkg.sv
// ============================================================================
//  Module      : product_acc_pkg
//  Description : Shared constants and width helper for the product accumulator.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package product_acc_pkg;

    localparam int COUNT_W = 16;

    // Sum width that can hold LEN full-scale products without overflow.
    function automatic int acc_width(input int width, input int len);
        return 2 * width + $clog2(len + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/product_accumulator_if.sv
// ============================================================================
//  Module      : product_accumulator_if
//  Description : Product input stream and valid/ready sum output bundle.
//                Optional max_product signal under PRODUCT_ACC_MAX_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface product_accumulator_if
    import product_acc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LEN   = 4
);
    localparam int ACC_W = acc_width(WIDTH, LEN);

    logic [2*WIDTH-1:0] P;
    logic               done;
    logic               clear;
    logic               sum_valid;
    logic               sum_ready;
    logic [ACC_W-1:0]   sum;
    logic [COUNT_W-1:0] group_count;
    logic               overflow;
`ifdef PRODUCT_ACC_MAX_EN
    logic [2*WIDTH-1:0] max_product;

    modport master (
        output P, done, clear, sum_ready,
        input  sum_valid, sum, group_count, overflow, max_product
    );

    modport slave (
        input  P, done, clear, sum_ready,
        output sum_valid, sum, group_count, overflow, max_product
    );
`else
    modport master (
        output P, done, clear, sum_ready,
        input  sum_valid, sum, group_count, overflow
    );

    modport slave (
        input  P, done, clear, sum_ready,
        output sum_valid, sum, group_count, overflow
    );
`endif

endinterface

`default_nettype wire

// File: rtl/sum_fifo.sv
// ============================================================================
//  Module      : sum_fifo
//  Description : Small synchronous FIFO with a registered head that keeps the
//                last popped value once the FIFO drains.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sum_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 2
) (
    input  wire logic          clock,
    input  wire logic          reset,
    input  wire logic          push,
    input  wire logic [DW-1:0] push_data,
    output logic               full,
    input  wire logic          pop,
    output logic [DW-1:0]      head,
    output logic               empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DW-1:0]    r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [DW-1:0]    r_head;

    logic             w_rd;
    logic             w_wr;
    logic [PTR_W-1:0] w_rd_next;
    logic [PTR_W-1:0] w_wr_next;

    assign empty = (r_count == '0);
    assign full  = (r_count == CNT_W'(DEPTH));
    assign head  = r_head;

    // A push into a full FIFO is legal when a pop frees a slot on the same edge.
    assign w_rd      = pop && !empty;
    assign w_wr      = push && (!full || w_rd);
    assign w_rd_next = (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
    assign w_wr_next = (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);

    always_ff @(posedge clock) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= w_wr_next;
            end
            if (w_rd) begin
                r_rd_ptr <= w_rd_next;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            // Head tracks the oldest entry; with nothing left it holds the value just popped.
            if (w_rd) begin
                if (r_count > CNT_W'(1)) begin
                    r_head <= r_mem[w_rd_next];
                end else if (w_wr) begin
                    r_head <= push_data;
                end
            end else if (empty && w_wr) begin
                r_head <= push_data;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/product_accumulator.sv
// ============================================================================
//  Module      : product_accumulator
//  Description : Sums every LEN multiplier products and queues the group sums.
//                Define PRODUCT_ACC_MAX_EN to add the max_product tracker.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module product_accumulator
    import product_acc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LEN   = 4,
    parameter int DEPTH = 2
) (
    input  wire logic              clock,
    input  wire logic              reset,
    product_accumulator_if.slave   bus
);

    localparam int ACC_W = acc_width(WIDTH, LEN);
    localparam int IDX_W = (LEN > 1) ? $clog2(LEN) : 1;

    logic [ACC_W-1:0]   r_acc;
    logic [IDX_W-1:0]   r_idx;
    logic [COUNT_W-1:0] r_group_count;
    logic               r_overflow;

    logic               w_accept;
    logic               w_last;
    logic               w_complete;
    logic [ACC_W-1:0]   w_sum_next;
    logic               w_full;
    logic               w_empty;
    logic [ACC_W-1:0]   w_head;
    logic               w_pop;
    logic               w_push;

    assign w_accept   = bus.done && !bus.clear;
    assign w_last     = (r_idx == IDX_W'(LEN - 1));
    assign w_complete = w_accept && w_last;
    assign w_sum_next = r_acc + ACC_W'(bus.P);
    assign w_pop      = !w_empty && bus.sum_ready;
    // The multiplier cannot stall, so a group finding no room is dropped.
    assign w_push     = w_complete && (!w_full || w_pop);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_acc <= '0;
            r_idx <= '0;
        end else if (bus.clear) begin
            r_acc <= '0;
            r_idx <= '0;
        end else if (bus.done) begin
            if (w_last) begin
                r_acc <= '0;
                r_idx <= '0;
            end else begin
                r_acc <= w_sum_next;
                r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_group_count <= '0;
            r_overflow    <= 1'b0;
        end else begin
            if (w_push) begin
                r_group_count <= r_group_count + COUNT_W'(1);
            end
            if (w_complete && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    sum_fifo #(
        .DW    (ACC_W),
        .DEPTH (DEPTH)
    ) u_sum_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (w_push),
        .push_data (w_sum_next),
        .full      (w_full),
        .pop       (w_pop),
        .head      (w_head),
        .empty     (w_empty)
    );

    assign bus.sum_valid   = !w_empty;
    assign bus.sum         = w_head;
    assign bus.group_count = r_group_count;
    assign bus.overflow    = r_overflow;

`ifdef PRODUCT_ACC_MAX_EN
    logic [2*WIDTH-1:0] r_max;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_max <= '0;
        end else if (w_accept && (bus.P > r_max)) begin
            r_max <= bus.P;
        end
    end

    assign bus.max_product = r_max;
`else
`endif

endmodule

`default_nettype wire
